// File: rtl/screen_sequencer.sv
// Game screen sequencer: button sync, frame-tick driven state machine
// (idle / play / game-over flash / game-over hold) and registered VGA pixel mux.
module screen_sequencer #(
   parameter int H_ACTIVE     = 800,
   parameter int V_ACTIVE     = 600,
   parameter int BLINK_FRAMES = 15,
   parameter int FLASH_FRAMES = 120
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] Hcount,
   input  logic [15:0] Vcount,
   input  logic        btn,
   input  logic        collision,
   input  logic [11:0] game_rgb,
   input  logic [11:0] over_rgb,
   output logic [3:0]  r_red,
   output logic [3:0]  r_green,
   output logic [3:0]  r_blue,
   output logic        game_run,
   output logic        game_reset,
   output logic [1:0]  state
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      PLAY       = 2'd1,
      OVER_FLASH = 2'd2,
      OVER_HOLD  = 2'd3
   } state_t;

   localparam logic [15:0] H_LIM     = 16'(H_ACTIVE);
   localparam logic [15:0] V_LIM     = 16'(V_ACTIVE);
   localparam logic [7:0]  BLINK_LIM = 8'(BLINK_FRAMES);
   localparam logic [7:0]  FLASH_LIM = 8'(FLASH_FRAMES);

   state_t      state_q, state_d;
   logic        btn_s1_q, btn_s2_q, btn_prev_q;
   logic        press_pend_q, press_pend_d;
   logic        coll_pend_q, coll_pend_d;
   logic [7:0]  frame_cnt_q, frame_cnt_d;
   logic [7:0]  blink_cnt_q, blink_cnt_d;
   logic        blink_q, blink_d;
   logic        game_reset_q, game_reset_d;
   logic [11:0] rgb_q, rgb_d;

   logic        press_evt, frame_tick, active;
   logic [7:0]  frame_inc, blink_inc;

   assign press_evt  = btn_s2_q & ~btn_prev_q;
   assign frame_tick = (Hcount == '0) && (Vcount == V_LIM);
   assign active     = (Hcount < H_LIM) && (Vcount < V_LIM);
   assign frame_inc  = frame_cnt_q + 8'd1;
   assign blink_inc  = blink_cnt_q + 8'd1;

   always_comb begin
      state_d      = state_q;
      press_pend_d = press_pend_q | press_evt;
      coll_pend_d  = coll_pend_q | collision;
      frame_cnt_d  = frame_cnt_q;
      blink_cnt_d  = blink_cnt_q;
      blink_d      = blink_q;
      game_reset_d = 1'b0;
      case (state_q)
         IDLE, OVER_HOLD: begin
            if (frame_tick && press_pend_q) begin
               state_d      = PLAY;
               press_pend_d = 1'b0;
               coll_pend_d  = 1'b0;
               game_reset_d = 1'b1;
            end
         end
         // A pending collision beats a pending press: both flags are dropped.
         PLAY: begin
            if (frame_tick && coll_pend_q) begin
               state_d      = OVER_FLASH;
               press_pend_d = 1'b0;
               coll_pend_d  = 1'b0;
               frame_cnt_d  = '0;
               blink_cnt_d  = '0;
               blink_d      = 1'b0;
            end
         end
         OVER_FLASH: begin
            press_pend_d = 1'b0;
            if (frame_tick) begin
               frame_cnt_d = frame_inc;
               blink_cnt_d = blink_inc;
               // Sub-counter wraps at BLINK_FRAMES, so toggles land on multiples of it.
               if (blink_inc == BLINK_LIM) begin
                  blink_cnt_d = '0;
                  blink_d     = ~blink_q;
               end
               if (frame_inc == FLASH_LIM) state_d = OVER_HOLD;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      rgb_d = '0;
      if (active) begin
         case (state_q)
            OVER_FLASH: rgb_d = blink_q ? over_rgb : game_rgb;
            OVER_HOLD:  rgb_d = over_rgb;
            default:    rgb_d = game_rgb;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         btn_s1_q     <= 1'b0;
         btn_s2_q     <= 1'b0;
         btn_prev_q   <= 1'b0;
         press_pend_q <= 1'b0;
         coll_pend_q  <= 1'b0;
         frame_cnt_q  <= '0;
         blink_cnt_q  <= '0;
         blink_q      <= 1'b0;
         game_reset_q <= 1'b0;
         rgb_q        <= '0;
      end else begin
         state_q      <= state_d;
         btn_s1_q     <= btn;
         btn_s2_q     <= btn_s1_q;
         btn_prev_q   <= btn_s2_q;
         press_pend_q <= press_pend_d;
         coll_pend_q  <= coll_pend_d;
         frame_cnt_q  <= frame_cnt_d;
         blink_cnt_q  <= blink_cnt_d;
         blink_q      <= blink_d;
         game_reset_q <= game_reset_d;
         rgb_q        <= rgb_d;
      end
   end

   assign state      = state_q;
   assign game_run   = (state_q == PLAY);
   assign game_reset = game_reset_q;
   assign r_red      = rgb_q[11:8];
   assign r_green    = rgb_q[7:4];
   assign r_blue     = rgb_q[3:0];

endmodule
